alu_flag_ctrl: RTL

Sequencing and status-register controller for the 16-bit ALU datapath and its Z/C/V/N flag generator. Accepts operation requests over a valid/ready handshake and drives the one-hot op select and operands into the datapath. It waits the datapath latency, then commits flags into an architectural status register using a per-class update mask. It also executes 32-bit "wide" arithmetic/logic operations as two chained 16-bit passes, low word first, and returns the result on a valid/ready response channel.

---
 rtl/alu_pkg.sv | 75 +++++++
 rtl/alu_status_reg.sv | 41 ++++
 rtl/alu_flag_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing / status-register controller.
// Contents:
//   - opcode index constants (0..15)
//   - FSM state encoding
//   - packed {z,c,v,n} flags struct
//   - opcode class masks and the op_class() decoder (class + flag update mask)
//   - one_hot() helper producing the datapath op select
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOT   = 4'd5;
   localparam logic [3:0] OP_SHL   = 4'd6;
   localparam logic [3:0] OP_SHR   = 4'd7;
   localparam logic [3:0] OP_SAR   = 4'd8;
   localparam logic [3:0] OP_ROL   = 4'd9;
   localparam logic [3:0] OP_ROR   = 4'd10;
   localparam logic [3:0] OP_ADC   = 4'd11;
   localparam logic [3:0] OP_SBC   = 4'd12;
   localparam logic [3:0] OP_CMP   = 4'd13;
   localparam logic [3:0] OP_PASSA = 4'd14;
   localparam logic [3:0] OP_PASSB = 4'd15;

   // Bit i set => opcode i belongs to the class.
   localparam logic [15:0] ARITH_MASK = 16'h3803;  // 0,1,11,12,13
   localparam logic [15:0] SHIFT_MASK = 16'h07C0;  // 6..10

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic z;
      logic c;
      logic v;
      logic n;
   } flags_t;

   typedef enum logic [1:0] {
      CLS_ARITH,
      CLS_SHIFT,
      CLS_LOGIC
   } op_cls_t;

   typedef struct packed {
      op_cls_t cls;
      flags_t  mask;  // 1 = this flag is written by a commit
   } op_info_t;

   function automatic op_info_t op_class(input logic [3:0] opcode);
      op_info_t info;
      if (ARITH_MASK[opcode]) begin
         info.cls  = CLS_ARITH;
         info.mask = flags_t'(4'b1111);
      end else if (SHIFT_MASK[opcode]) begin
         info.cls  = CLS_SHIFT;
         info.mask = flags_t'(4'b1101);
      end else begin
         info.cls  = CLS_LOGIC;
         info.mask = flags_t'(4'b1001);
      end
      return info;
   endfunction

   function automatic logic [15:0] one_hot(input logic [3:0] opcode);
      return 16'h0001 << opcode;
   endfunction

endpackage

// File: rtl/alu_status_reg.sv
// Architectural status register {Z,C,V,N}.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (loads FLAG_RST)
//   commit_en     end-of-operation flag commit
//   commit_mask   per-bit update mask for the commit
//   commit_flags  flag values to commit
//   wr_en/wr_data software write of all four bits
//   flags         current register value
// A software write is applied first; a coinciding commit then overrides
// only the bits it owns, so the write survives in the unmasked bits.
module alu_status_reg #(
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       commit_en,
   input  logic [3:0] commit_mask,
   input  logic [3:0] commit_flags,
   input  logic       wr_en,
   input  logic [3:0] wr_data,
   output logic [3:0] flags
);

   logic [3:0] flags_d;

   always_comb begin
      flags_d = wr_en ? wr_data : flags;
      if (commit_en) begin
         flags_d = (commit_flags & commit_mask) | (flags_d & ~commit_mask);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= FLAG_RST;
      end else begin
         flags <= flags_d;
      end
   end

endmodule

// File: rtl/alu_flag_ctrl.sv
// Sequencer and status-register controller for the 16-bit ALU datapath.
// Ports:
//   req_*          request channel (valid/ready), opcode, wide flag, operands
//   alu_*          datapath drive (issue pulse, one-hot op, operands, carry)
//                  and datapath return (result, Z/C/V/N)
//   rsp_*          response channel (valid/ready), result, error
//   flag_wr_*      software write of the status register
//   flags          architectural status register {Z,C,V,N}
//   busy           high whenever the FSM is not in IDLE
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds with stable payload until then.
// A wide operation runs the low 16-bit pass, then the high pass, and commits
// flags once at the end. A wide shift is rejected with rsp_err and no pass.
module alu_flag_ctrl
   import alu_pkg::*;
#(
   parameter int         ALU_LAT  = 1,
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_opcode,
   input  logic        req_wide,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        alu_issue,
   output logic [15:0] alu_op_sel,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_carry_in,
   input  logic [15:0] alu_result,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_v,
   input  logic        alu_n,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_err,
   input  logic        flag_wr_en,
   input  logic [3:0]  flag_wr_data,
   output logic [3:0]  flags,
   output logic        busy
);

   state_t      state, state_next;
   logic [2:0]  cnt;
   logic [3:0]  op_r;
   logic        wide_r;
   logic        hi_pass;
   logic [15:0] a_hi, b_hi, res_lo;
   logic        z_lo;
   op_info_t    info_req, info_r;
   logic        accept, wide_shift, pass_done, low_done, commit_en;
   logic [3:0]  commit_flags;
   logic        c_now;

   assign info_req   = op_class(req_opcode);
   assign info_r     = op_class(op_r);
   assign accept     = (state == ST_IDLE) && req_valid;
   assign wide_shift = req_wide && (info_req.cls == CLS_SHIFT);
   assign pass_done  = (state == ST_WAIT) && (cnt == 3'd0);
   assign low_done   = pass_done && wide_r && !hi_pass;
   assign commit_en  = pass_done && !low_done;
   // Wide Z spans both halves; C/V/N come from whichever pass just ended.
   assign commit_flags = {(wide_r ? (z_lo & alu_z) : alu_z), alu_c, alu_v, alu_n};
   // Carry as it will read after this edge, so a write landing on the
   // accept edge still feeds ADC/SBC.
   assign c_now = flag_wr_en ? flag_wr_data[2] : flags[2];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (req_valid) state_next = wide_shift ? ST_RESP : ST_ISSUE;
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT:  if (cnt == 3'd0) state_next = low_done ? ST_ISSUE : ST_RESP;
         ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: pure decodes of the state register
   always_comb begin
      req_ready = (state == ST_IDLE);
      alu_issue = (state == ST_ISSUE);
      rsp_valid = (state == ST_RESP);
      busy      = (state != ST_IDLE);
   end

   // Operand, counter and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= 3'd0;
         op_r         <= 4'd0;
         wide_r       <= 1'b0;
         hi_pass      <= 1'b0;
         a_hi         <= 16'h0;
         b_hi         <= 16'h0;
         res_lo       <= 16'h0;
         z_lo         <= 1'b0;
         alu_op_sel   <= 16'h0;
         alu_a        <= 16'h0;
         alu_b        <= 16'h0;
         alu_carry_in <= 1'b0;
         rsp_result   <= 32'h0;
         rsp_err      <= 1'b0;
      end else begin
         if (accept) begin
            op_r       <= req_opcode;
            wide_r     <= req_wide;
            a_hi       <= req_a[31:16];
            b_hi       <= req_b[31:16];
            hi_pass    <= 1'b0;
            rsp_err    <= wide_shift;
            rsp_result <= 32'h0;
            if (!wide_shift) begin
               alu_op_sel   <= one_hot(req_opcode);
               alu_a        <= req_a[15:0];
               alu_b        <= req_b[15:0];
               alu_carry_in <= ((req_opcode == OP_ADC) || (req_opcode == OP_SBC)) ? c_now : 1'b0;
            end
         end

         if (state == ST_ISSUE) begin
            cnt <= 3'(ALU_LAT);
         end else if ((state == ST_WAIT) && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
         end

         // End of wide low pass: keep the low half, chain the carry for
         // arithmetic, and set up the high-half operands (op_sel is kept).
         if (low_done) begin
            res_lo       <= alu_result;
            z_lo         <= alu_z;
            hi_pass      <= 1'b1;
            alu_a        <= a_hi;
            alu_b        <= b_hi;
            alu_carry_in <= (info_r.cls == CLS_ARITH) ? alu_c : 1'b0;
         end

         if (commit_en) begin
            rsp_result   <= wide_r ? {alu_result, res_lo} : {16'h0, alu_result};
            alu_op_sel   <= 16'h0;
            alu_carry_in <= 1'b0;
         end
      end
   end

   alu_status_reg #(
      .FLAG_RST(FLAG_RST)
   ) u_status (
      .clk         (clk),
      .rst         (rst),
      .commit_en   (commit_en),
      .commit_mask (info_r.mask),
      .commit_flags(commit_flags),
      .wr_en       (flag_wr_en),
      .wr_data     (flag_wr_data),
      .flags       (flags)
   );

endmodule
